spi_fifo_sequencer: RTL and testbench

SPI master sequencer that drains the APB-fed TX FIFO and fills the RX FIFO of the APB-to-SPI bridge. While enabled and words are pending, it pops one TX word, shifts it out full-duplex in SPI mode 0 (MSB first) and pushes the simultaneously captured MISO word into the RX FIFO. It keeps chip select asserted across back-to-back words and stalls when the RX FIFO is full. It sits between the FIFO block's core-side ports and the SPI pins.

---
 rtl/spi_fifo_sequencer_if.sv | 28 ++
 rtl/spi_fifo_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_spi_fifo_sequencer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_fifo_sequencer_if.sv
// FIFO-side and SPI-pin signals of the SPI FIFO sequencer.
// The master modport is the sequencer's view; slave is the FIFO/SPI-slave side.
interface spi_fifo_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  enable;
    logic                  empty_tx;
    logic [DATA_WIDTH-1:0] fifo_r_data_tx;
    logic                  read_fifo_tx;
    logic                  full_rx;
    logic                  write_fifo_rx;
    logic [DATA_WIDTH-1:0] fifo_w_data_rx;
    logic                  sclk;
    logic                  mosi;
    logic                  miso;
    logic                  cs_n;
    logic                  busy;

    modport master (
        input  enable, empty_tx, fifo_r_data_tx, full_rx, miso,
        output read_fifo_tx, write_fifo_rx, fifo_w_data_rx, sclk, mosi, cs_n, busy
    );

    modport slave (
        output enable, empty_tx, fifo_r_data_tx, full_rx, miso,
        input  read_fifo_tx, write_fifo_rx, fifo_w_data_rx, sclk, mosi, cs_n, busy
    );
endinterface

// File: rtl/spi_fifo_sequencer.sv
// SPI mode-0 master that pops TX FIFO words, shifts them out MSB first and
// pushes the captured MISO word into the RX FIFO, holding cs_n across bursts.
module spi_fifo_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int CLK_DIV    = 4
) (
    input  logic                 pclk,
    input  logic                 preset,
    spi_fifo_sequencer_if.master bus
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_PUSH  = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    state_t                state_r;
    state_t                state_next_s;
    logic [DIV_W-1:0]      div_r;
    logic [CNT_W-1:0]      bit_cnt_r;
    logic [DATA_WIDTH-1:0] tx_sh_r;
    logic [DATA_WIDTH-1:0] rx_sh_r;
    logic                  sclk_r;
    logic                  cs_n_r;
    logic                  busy_r;
    logic                  lead_r;
    logic                  div_done_s;
    logic                  start_s;
    logic                  load_s;
    logic                  write_s;
    logic                  rise_s;
    logic                  fall_s;

    assign div_done_s = (div_r == DIV_LAST);
    assign start_s    = bus.enable && !bus.empty_tx;

    // Next-state and per-cycle strobes
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        write_s      = 1'b0;
        rise_s       = 1'b0;
        fall_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    load_s       = 1'b1;
                    state_next_s = ST_SETUP;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (div_done_s) begin
                    state_next_s = ST_SHIFT;
                end else begin
                    state_next_s = ST_SETUP;
                end
            end
            ST_SHIFT: begin
                // lead_r stretches the first low half after a back-to-back load
                if (div_done_s && !lead_r) begin
                    if (!sclk_r) begin
                        rise_s       = 1'b1;
                        state_next_s = ST_SHIFT;
                    end else begin
                        fall_s = 1'b1;
                        if (bit_cnt_r == BIT_LAST) begin
                            state_next_s = ST_PUSH;
                        end else begin
                            state_next_s = ST_SHIFT;
                        end
                    end
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            ST_PUSH: begin
                if (!bus.full_rx) begin
                    write_s = 1'b1;
                    if (start_s) begin
                        load_s       = 1'b1;
                        state_next_s = ST_SHIFT;
                    end else begin
                        state_next_s = ST_HOLD;
                    end
                end else begin
                    state_next_s = ST_PUSH;
                end
            end
            ST_HOLD: begin
                if (div_done_s) begin
                    state_next_s = ST_GAP;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            ST_GAP: begin
                if (div_done_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_GAP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Divider, shift registers and registered pin outputs
    always_ff @(posedge pclk) begin
        if (preset) begin
            div_r     <= '0;
            bit_cnt_r <= '0;
            tx_sh_r   <= '0;
            rx_sh_r   <= '0;
            sclk_r    <= 1'b0;
            cs_n_r    <= 1'b1;
            busy_r    <= 1'b0;
            lead_r    <= 1'b0;
        end else begin
            if ((state_next_s != state_r) || div_done_s) begin
                div_r <= '0;
            end else begin
                div_r <= div_r + DIV_W'(1);
            end

            if (load_s && (state_r == ST_PUSH)) begin
                lead_r <= 1'b1;
            end else if ((state_r == ST_SHIFT) && div_done_s) begin
                lead_r <= 1'b0;
            end

            if (rise_s) begin
                sclk_r <= 1'b1;
            end else if (fall_s) begin
                sclk_r <= 1'b0;
            end

            if (load_s) begin
                tx_sh_r   <= bus.fifo_r_data_tx;
                rx_sh_r   <= '0;
                bit_cnt_r <= '0;
            end else begin
                if (fall_s) begin
                    tx_sh_r   <= tx_sh_r << 1;
                    bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                end
                if (rise_s) begin
                    rx_sh_r <= {rx_sh_r[DATA_WIDTH-2:0], bus.miso};
                end
            end

            cs_n_r <= (state_next_s == ST_IDLE) || (state_next_s == ST_GAP);
            busy_r <= (state_next_s != ST_IDLE);
        end
    end

    assign bus.read_fifo_tx   = load_s && !preset;
    assign bus.write_fifo_rx  = write_s && !preset;
    assign bus.fifo_w_data_rx = rx_sh_r;
    assign bus.mosi           = tx_sh_r[DATA_WIDTH-1];
    assign bus.sclk           = sclk_r;
    assign bus.cs_n           = cs_n_r;
    assign bus.busy           = busy_r;
endmodule

// File: tb/tb_spi_fifo_sequencer.sv
// Bench for spi_fifo_sequencer: FIFO model, echoing mode-0 SPI slave and
// word-level timing expectations derived from the latency formulas.
module tb_spi_fifo_sequencer;
    localparam int DW = 8;
    localparam int CD = 2;
    localparam int P  = 1 + CD + 2 * DW * CD;
    localparam int HN = 4096;

    logic pclk   = 1'b0;
    logic preset = 1'b1;
    always #5 pclk = ~pclk;

    spi_fifo_sequencer_if #(.DATA_WIDTH(DW)) dut_if ();
    spi_fifo_sequencer #(.DATA_WIDTH(DW), .CLK_DIV(CD)) dut (
        .pclk(pclk), .preset(preset), .bus(dut_if.master));

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    // Show-ahead TX FIFO model
    logic [DW-1:0] tx_q[$];
    always @(posedge pclk) begin
        if (dut_if.read_fifo_tx === 1'b1 && tx_q.size() > 0) void'(tx_q.pop_front());
        dut_if.empty_tx       <= (tx_q.size() == 0);
        dut_if.fifo_r_data_tx <= (tx_q.size() > 0) ? tx_q[0] : '0;
    end

    // Mode-0 slave: first word of a cs_n burst returns slave_seed, later words echo the previous MOSI word
    logic [DW-1:0] slave_seed = '0;
    logic [DW-1:0] sl_sh = '0, sl_rcv = '0;
    int sl_bits = 0;
    logic sclk_p = 1'b0, cs_p = 1'b1;
    assign dut_if.miso = sl_sh[DW-1];
    always @(posedge pclk) begin
        if (cs_p && dut_if.cs_n === 1'b0) begin
            sl_sh <= slave_seed; sl_bits <= 0;
        end else if (dut_if.cs_n === 1'b0 && sclk_p && dut_if.sclk === 1'b0) begin
            if (sl_bits == DW) begin sl_sh <= sl_rcv; sl_bits <= 0; end
            else sl_sh <= sl_sh << 1;
        end else if (dut_if.cs_n === 1'b0 && !sclk_p && dut_if.sclk === 1'b1) begin
            sl_rcv <= {sl_rcv[DW-2:0], dut_if.mosi}; sl_bits <= sl_bits + 1;
        end
        sclk_p <= (dut_if.sclk === 1'b1);
        cs_p   <= (dut_if.cs_n !== 1'b0);
    end

    // Event log sampled mid-cycle
    logic cs_h[HN], sclk_h[HN], busy_h[HN];
    int pop_c[$], push_c[$];
    logic [DW-1:0] push_d[$];
    int bad_pop = 0, bad_push = 0, rises = 0;
    logic sclk_m = 1'b0;
    always @(negedge pclk) begin
        cs_h[cyc % HN]   <= dut_if.cs_n;
        sclk_h[cyc % HN] <= dut_if.sclk;
        busy_h[cyc % HN] <= dut_if.busy;
        if (dut_if.read_fifo_tx === 1'b1) begin
            pop_c.push_back(cyc);
            if (preset || dut_if.empty_tx) bad_pop <= bad_pop + 1;
        end
        if (dut_if.write_fifo_rx === 1'b1) begin
            push_c.push_back(cyc);
            push_d.push_back(dut_if.fifo_w_data_rx);
            if (preset || dut_if.full_rx) bad_push <= bad_push + 1;
        end
        if (dut_if.sclk === 1'b1 && sclk_m === 1'b0) rises <= rises + 1;
        sclk_m <= dut_if.sclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic wait_pop(input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge pclk);
            if (dut_if.read_fifo_tx === 1'b1) begin t = cyc; break; end
        end
        chk("wait_pop", 32'(t >= 0), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        bit done = 1'b0;
        repeat (2) @(negedge pclk);
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge pclk);
            if (dut_if.busy === 1'b0) done = 1'b1;
        end
        chk("wait_idle", 32'(done), 32'd1);
        tick(2);
    endtask

    logic [DW-1:0] burst_w[$];

    // Word k pops at t0+k*P(+stall), pushes at t0+(k+1)*P+stall; data = seed, then echo of word k-1
    task automatic check_burst(input string tag, input int p0, input int q0, input int t0,
                               input int n, input int s, input logic [DW-1:0] seed);
        logic [DW-1:0] ed;
        chk({tag, "_pops"}, 32'(pop_c.size() - p0), 32'(n));
        chk({tag, "_pushes"}, 32'(push_c.size() - q0), 32'(n));
        for (int k = 0; k < n; k++) begin
            if (k > 0)
                chk($sformatf("%s_pop%0d_cycle", tag, k),
                    (p0 + k < pop_c.size()) ? 32'(pop_c[p0 + k]) : 32'hFFFF_FFFF, 32'(t0 + k * P + s));
            chk($sformatf("%s_push%0d_cycle", tag, k),
                (q0 + k < push_c.size()) ? 32'(push_c[q0 + k]) : 32'hFFFF_FFFF, 32'(t0 + (k + 1) * P + s));
            ed = (k == 0) ? seed : burst_w[k - 1];
            chk($sformatf("%s_push%0d_data", tag, k),
                (q0 + k < push_d.size()) ? 32'(push_d[q0 + k]) : 32'hFFFF_FFFF, 32'(ed));
        end
    endtask

    initial begin
        int t0, rel, p0, q0, r0, bad, n, s;
        logic [DW-1:0] seed;
        dut_if.enable  = 1'b1;
        dut_if.full_rx = 1'b0;
        slave_seed     = 8'h3C;
        tx_q.push_back(8'hA5);

        // Reset held with a word pending
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            chk("rst_read", 32'(dut_if.read_fifo_tx), 32'd0);
            chk("rst_write", 32'(dut_if.write_fifo_rx), 32'd0);
            chk("rst_outs", {25'd0, dut_if.cs_n, dut_if.sclk, dut_if.mosi, dut_if.busy, 3'd0}, 32'h40);
            chk("rst_data", 32'(dut_if.fifo_w_data_rx), 32'd0);
        end
        tick(1);
        preset = 1'b0;
        rel = cyc;

        // Single word
        p0 = pop_c.size(); q0 = push_c.size(); r0 = rises;
        wait_pop(20, t0);
        chk("single_pop_cycle", 32'(t0), 32'(rel));
        wait_idle(100);
        burst_w = {8'hA5};
        check_burst("single", p0, q0, t0, 1, 0, 8'h3C);
        chk("single_rises", 32'(rises - r0), 32'd8);
        chk("single_mosi_bits", 32'(sl_rcv), 32'hA5);
        bad = 0;
        for (int c = t0 + 1; c <= t0 + 37; c++) if (cs_h[c % HN] !== 1'b0) bad++;
        for (int c = t0 + 38; c <= t0 + 39; c++) if (cs_h[c % HN] !== 1'b1) bad++;
        chk("single_cs_window", 32'(bad), 32'd0);
        chk("single_busy_39", 32'(busy_h[(t0 + 39) % HN]), 32'd1);
        chk("single_busy_40", 32'(busy_h[(t0 + 40) % HN]), 32'd0);

        // Back-to-back
        slave_seed = 8'h5A;
        p0 = pop_c.size(); q0 = push_c.size();
        burst_w = {8'h01, 8'h80, 8'hFF};
        foreach (burst_w[i]) tx_q.push_back(burst_w[i]);
        wait_pop(20, t0);
        wait_idle(400);
        check_burst("b2b", p0, q0, t0, 3, 0, 8'h5A);
        bad = 0;
        for (int c = t0 + 1; c <= t0 + 3 * P + 2; c++) if (cs_h[c % HN] !== 1'b0) bad++;
        chk("b2b_cs_low", 32'(bad), 32'd0);
        for (int k = 0; k < 2; k++) begin
            bad = 0;
            for (int d = 0; d <= 2 * CD; d++) if (sclk_h[(t0 + (k + 1) * P + d) % HN] !== 1'b0) bad++;
            if (sclk_h[(t0 + (k + 1) * P + 2 * CD + 1) % HN] !== 1'b1) bad++;
            chk($sformatf("b2b_gap%0d_sclk_low", k), 32'(bad), 32'd0);
        end

        // RX full stall of 10 cycles at the first push
        slave_seed = 8'h77;
        p0 = pop_c.size(); q0 = push_c.size();
        burst_w = {8'h33, 8'hC6};
        foreach (burst_w[i]) tx_q.push_back(burst_w[i]);
        wait_pop(20, t0);
        tick(P);
        dut_if.full_rx = 1'b1;
        tick(10);
        dut_if.full_rx = 1'b0;
        wait_idle(300);
        check_burst("stall", p0, q0, t0, 2, 10, 8'h77);
        bad = 0;
        for (int c = t0 + P; c < t0 + P + 10; c++) if (sclk_h[c % HN] !== 1'b0) bad++;
        chk("stall_sclk_low", 32'(bad), 32'd0);

        // Enable dropped mid-word with two words queued
        slave_seed = 8'h11;
        p0 = pop_c.size(); q0 = push_c.size();
        tx_q.push_back(8'h42); tx_q.push_back(8'h99);
        wait_pop(20, t0);
        tick(10);
        dut_if.enable = 1'b0;
        wait_idle(200);
        burst_w = {8'h42};
        check_burst("endrop", p0, q0, t0, 1, 0, 8'h11);
        chk("endrop_hold_cs", 32'(cs_h[(t0 + 37) % HN]), 32'd0);
        chk("endrop_gap_cs", {30'd0, cs_h[(t0 + 38) % HN], cs_h[(t0 + 39) % HN]}, 32'd3);
        chk("endrop_idle_busy", 32'(busy_h[(t0 + 40) % HN]), 32'd0);
        chk("endrop_left_in_fifo", 32'(tx_q.size()), 32'd1);
        chk("endrop_empty_tx", 32'(dut_if.empty_tx), 32'd0);

        // Reset mid-word, then restart with a fresh word
        slave_seed = 8'hE1;
        dut_if.enable = 1'b1;
        q0 = push_c.size();
        wait_pop(20, t0);
        tick(20);
        preset = 1'b1;
        tick(1);
        preset = 1'b0;
        @(negedge pclk);
        chk("rstmid_outs", {29'd0, dut_if.cs_n, dut_if.sclk, dut_if.busy}, 32'h4);
        chk("rstmid_write", 32'(dut_if.write_fifo_rx), 32'd0);
        tick(5);
        chk("rstmid_no_push", 32'(push_c.size() - q0), 32'd0);
        chk("rstmid_fifo_empty", 32'(tx_q.size()), 32'd0);
        p0 = pop_c.size(); q0 = push_c.size();
        burst_w = {8'h5C};
        tx_q.push_back(8'h5C);
        wait_pop(20, t0);
        wait_idle(100);
        check_burst("restart", p0, q0, t0, 1, 0, 8'hE1);

        // Randomized bursts with an optional stall on the first push
        for (int it = 0; it < 3; it++) begin
            n = $urandom_range(2, 4);
            s = $urandom_range(0, 6);
            seed = DW'($urandom);
            slave_seed = seed;
            burst_w.delete();
            for (int i = 0; i < n; i++) burst_w.push_back(DW'($urandom));
            p0 = pop_c.size(); q0 = push_c.size();
            foreach (burst_w[i]) tx_q.push_back(burst_w[i]);
            wait_pop(20, t0);
            if (s > 0) begin
                tick(P);
                dut_if.full_rx = 1'b1;
                tick(s);
                dut_if.full_rx = 1'b0;
            end
            wait_idle(400);
            check_burst($sformatf("rand%0d", it), p0, q0, t0, n, s, seed);
        end

        chk("never_pop_bad", 32'(bad_pop), 32'd0);
        chk("never_push_bad", 32'(bad_push), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
